hyperbus_trans_scheduler: RTL
=============================

HYPERBUS_TRANS_SCHEDULER -- requirements
Module: hyperbus_trans_scheduler

Interface
REQ-001 SHALL have parameter BURST_WIDTH, default 12: width of the PHY burst field.
REQ-002 SHALL have parameter NR_CS, default 2: number of chip selects (power of two).
REQ-003 SHALL have parameter MAX_BURST, default 256: maximum 16-bit words per PHY transaction, 1..2^BURST_WIDTH-1.
REQ-004 SHALL have parameter CS_ADDR_LSB, default 24: lowest byte-address bit of the chip-select index field.
REQ-005 SHALL have port clk_i, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have ports req_valid_i and req_ready_o, in/out, 2: per-requester handshake; index 0 and index 1.
REQ-008 SHALL have ports req_addr_i, in, 2x32: byte address; req_len_i, in, 2x16: length in 16-bit words.
REQ-009 SHALL have ports req_write_i, in, 2 and req_addr_space_i, in, 2: write flag and register-space flag.
REQ-010 SHALL have port req_done_o, out, 2: one-cycle completion pulse per requester.
REQ-011 SHALL have ports trans_valid_o, out, 1 and trans_ready_i, in, 1: PHY transaction handshake.
REQ-012 SHALL have ports trans_address_o, out, 32; trans_cs_o, out, NR_CS; trans_write_o, out, 1; trans_burst_o, out, BURST_WIDTH; trans_address_space_o, out, 1.
REQ-013 SHALL have port beat_i, in, 1: one pulse per completed 16-bit data word on the PHY (tx or rx handshake).

Function
REQ-014 SHALL implement states IDLE, ISSUE, DATA, DONE.
REQ-015 IDLE: if any req_valid_i is high, SHALL grant one requester, assert its req_ready_o for exactly that cycle, latch its fields, and go to ISSUE (or to DONE if req_len_i==0).
REQ-016 Arbitration SHALL be round-robin: with both valid, the requester not granted last wins; after reset requester 0 has priority.
REQ-017 req_ready_o SHALL be low in every state except the IDLE grant cycle; at most one bit high.
REQ-018 ISSUE: trans_valid_o SHALL be high and all trans_* outputs stable until trans_valid_o && trans_ready_i, then go to DATA next cycle; trans_valid_o low in all other states.
REQ-019 Chunk burst SHALL be min(remaining, MAX_BURST); if the latched addr_space flag is 1 the burst SHALL be 1 and the request is one chunk regardless of length.
REQ-020 trans_cs_o SHALL be one-hot, bit index = address[CS_ADDR_LSB +: log2(NR_CS)] of the current chunk.
REQ-021 DATA: each beat_i SHALL increment the beat counter; when the count equals the chunk burst, remaining -= burst, address += 2*burst (32-bit wrap-around), and the state goes to ISSUE if remaining>0, else DONE.
REQ-022 beat_i SHALL be ignored outside DATA; beat_i and trans_ready_i in the same cycle SHALL count the beat only if already in DATA.
REQ-023 DONE: req_done_o of the granted requester SHALL pulse for one cycle, the round-robin pointer SHALL update, then the state goes to IDLE; a new grant occurs no earlier than the cycle after DONE.
REQ-024 Only one request SHALL be in flight; a requester whose valid drops while not granted SHALL be dropped from arbitration without side effects.

Reset
REQ-025 On rst_ni low, state SHALL go to IDLE immediately, asynchronously, even mid-transaction; all outputs SHALL be 0 (trans_cs_o all zero, req_ready_o 2'b00) and the priority pointer SHALL be reset to requester 0.
REQ-026 After reset release, the first grant SHALL occur no earlier than the first rising clk_i edge with a valid request.

Verification
REQ-027 Req0 read, addr 0x100, len 4, trans_ready_i tied high -> one transaction, burst 4, cs 2'b01, 4 beats, req_done_o[0] pulse once.
REQ-028 Req1 write, addr 0x01000000, len 600, MAX_BURST 256 -> bursts 256, 256, 88 at addresses 0x01000000, 0x01000200, 0x01000400, cs 2'b10, single done pulse.
REQ-029 Both valid continuously from reset -> grants 0,1,0,1 alternate, req_ready_o never 2'b11.
REQ-030 Requester with addr_space=1, len 8 -> one transaction, burst 1, trans_address_space_o=1; len 0 -> no trans_valid_o, done pulse.
REQ-031 trans_ready_i held low for 5 cycles -> trans_valid_o and fields stable throughout; beat_i pulses during ISSUE ignored.
REQ-032 rst_ni asserted during DATA of a 3-chunk request -> all outputs 0 in same cycle; after release, fresh request served normally with req0 priority.

Source files
------------

// File: rtl/hyperbus_trans_scheduler.sv
// hyperbus_trans_scheduler: arbitrates two requesters and splits each request into PHY bursts.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_valid_i/req_ready_o       per-requester handshake (ready pulses only in the grant cycle)
//   req_addr_i/req_len_i          byte address and length in 16-bit words
//   req_write_i/req_addr_space_i  write flag and register-space flag
//   req_done_o                    one-cycle completion pulse per requester
//   trans_*                       PHY transaction handshake and fields
//   beat_i                        one pulse per completed 16-bit word on the PHY
module hyperbus_trans_scheduler #(
    parameter int BURST_WIDTH = 12,
    parameter int NR_CS       = 2,
    parameter int MAX_BURST   = 256,
    parameter int CS_ADDR_LSB = 24
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [1:0]             req_valid_i,
    output logic [1:0]             req_ready_o,
    input  logic [1:0][31:0]       req_addr_i,
    input  logic [1:0][15:0]       req_len_i,
    input  logic [1:0]             req_write_i,
    input  logic [1:0]             req_addr_space_i,
    output logic [1:0]             req_done_o,
    output logic                   trans_valid_o,
    input  logic                   trans_ready_i,
    output logic [31:0]            trans_address_o,
    output logic [NR_CS-1:0]       trans_cs_o,
    output logic                   trans_write_o,
    output logic [BURST_WIDTH-1:0] trans_burst_o,
    output logic                   trans_address_space_o,
    input  logic                   beat_i
);
    localparam int CSW = (NR_CS > 1) ? $clog2(NR_CS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DATA, DONE} state_e;

    state_e                 state_q, state_d;
    logic                   gnt_q, gnt_d;
    logic                   prio_q, prio_d;
    logic                   write_q, write_d;
    logic                   space_q, space_d;
    logic [31:0]            addr_q, addr_d;
    logic [15:0]            rem_q, rem_d;
    logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
    logic                   sel;
    logic [BURST_WIDTH-1:0] burst;
    logic [BURST_WIDTH-1:0] cnt_inc;
    logic [15:0]            rem_sub;

    // prio_q holds the requester that wins a tie; the other one is taken only when it alone is valid
    assign sel     = req_valid_i[prio_q] ? prio_q : ~prio_q;
    // register-space accesses are always a single one-word transaction
    assign burst   = space_q ? BURST_WIDTH'(1)
                   : (rem_q < 16'(MAX_BURST) ? BURST_WIDTH'(rem_q) : BURST_WIDTH'(MAX_BURST));
    assign cnt_inc = cnt_q + BURST_WIDTH'(1);
    assign rem_sub = space_q ? '0 : rem_q - 16'(burst);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        prio_d      = prio_q;
        write_d     = write_q;
        space_d     = space_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        req_ready_o = '0;
        req_done_o  = '0;
        unique case (state_q)
            IDLE: begin
                // rst_ni gates the grant so no ready appears while reset is held
                if (rst_ni && |req_valid_i) begin
                    req_ready_o[sel] = 1'b1;
                    gnt_d            = sel;
                    addr_d           = req_addr_i[sel];
                    rem_d            = req_len_i[sel];
                    write_d          = req_write_i[sel];
                    space_d          = req_addr_space_i[sel];
                    cnt_d            = '0;
                    state_d          = (req_len_i[sel] == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (trans_ready_i) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (beat_i) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == burst) begin
                        cnt_d   = '0;
                        rem_d   = rem_sub;
                        addr_d  = addr_q + (32'(burst) << 1);
                        state_d = (rem_sub != '0) ? ISSUE : DONE;
                    end
                end
            end
            DONE: begin
                req_done_o[gnt_q] = 1'b1;
                prio_d            = ~gnt_q;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            prio_q  <= 1'b0;
            write_q <= 1'b0;
            space_q <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
            write_q <= write_d;
            space_q <= space_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    // transaction fields are forced to zero outside ISSUE so idle and reset present a clean bus
    assign trans_valid_o         = (state_q == ISSUE);
    assign trans_address_o       = trans_valid_o ? addr_q : '0;
    assign trans_cs_o            = trans_valid_o ? (NR_CS'(1) << addr_q[CS_ADDR_LSB +: CSW]) : '0;
    assign trans_write_o         = trans_valid_o & write_q;
    assign trans_burst_o         = trans_valid_o ? burst : '0;
    assign trans_address_space_o = trans_valid_o & space_q;
endmodule
